// File: rtl/memoria_pkg.sv
// memoria_pkg: shared definitions for the memory controller slice.
// Holds the FSM state encoding, the requester port ids, the default memory
// depth and the address range check used at acceptance time.
package memoria_pkg;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    ESCRITA  = 2'd1,
    LEITURA  = 2'd2,
    RESPOSTA = 2'd3
  } estado_t;

  localparam logic PORTA_INST = 1'b0;
  localparam logic PORTA_DADO = 1'b1;

  localparam int unsigned PROFUNDIDADE_PADRAO = 512;

  // A word address is valid only when strictly below the memory depth.
  function automatic logic fora_de_faixa(input logic [31:0] ender,
                                         input int unsigned prof);
    return (ender >= prof);
  endfunction

endpackage

// File: rtl/arbitro_memoria.sv
// arbitro_memoria: combinational grant selection between the instruction
// fetch port and the data port.
// Optional feature macro: ARB_ROUND_ROBIN_EN. When defined, a collision is
// resolved in favour of the port held in the pointer (the port not served
// last) and the next pointer value is produced here; when undefined the data
// port always wins.
module arbitro_memoria
  import memoria_pkg::*;
(
  input  logic inst_req_i,
  input  logic dado_req_i,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic ptr_i,
  output logic ptr_d_o,
`endif
  output logic valido_o,
  output logic porta_o
);

  // Pick the port to serve; the pointer moves away from whoever is granted.
  always_comb begin
    valido_o = inst_req_i | dado_req_i;
    porta_o  = PORTA_DADO;
    if (inst_req_i && dado_req_i) begin
`ifdef ARB_ROUND_ROBIN_EN
      porta_o = ptr_i;
`else
      porta_o = PORTA_DADO;
`endif
    end else if (inst_req_i) begin
      porta_o = PORTA_INST;
    end
`ifdef ARB_ROUND_ROBIN_EN
    ptr_d_o = ptr_i;
    if (valido_o) begin
      ptr_d_o = ~porta_o;
    end
`endif
  end

endmodule

// File: rtl/controlador_memoria.sv
// controlador_memoria: initiator side of the shared instruction/data memory.
// Arbitrates the instruction fetch port and the data port onto one memory
// interface, sequences each access with an FSM and returns a one-cycle
// completion pulse to the granted requester. All outputs are registered.
// Optional feature macro: ARB_ROUND_ROBIN_EN (round-robin collision
// resolution instead of fixed data-port priority).
module controlador_memoria
  import memoria_pkg::*;
#(
  parameter int unsigned PROFUNDIDADE = PROFUNDIDADE_PADRAO,
  parameter int unsigned LAT_LEITURA  = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        inst_req,
  input  logic [31:0] inst_end,
  output logic        inst_pronto,
  output logic [31:0] inst_dado,
  input  logic        dado_req,
  input  logic        dado_esc,
  input  logic [31:0] dado_end,
  input  logic [31:0] dado_wdata,
  output logic        dado_pronto,
  output logic [31:0] dado_rdata,
  output logic        erro,
  output logic [31:0] mem_endereco,
  output logic [31:0] mem_indata,
  output logic        mem_lerMem,
  output logic        mem_escMem,
  input  logic [31:0] mem_output,
  output logic        ocupado
);

  // The read strobe is held LAT_LEITURA cycles; the counter runs down to 0.
  localparam logic [3:0] CONT_INICIAL = 4'(LAT_LEITURA - 1);

  logic        valido_d;
  logic        porta_d;
  logic        esc_d;
  logic        fora_d;
  logic [31:0] end_d;
  logic [31:0] wdata_d;

  estado_t     estado_q;
  logic        porta_q;
  logic        falha_q;
  logic [3:0]  cont_q;
  logic        inst_pronto_q;
  logic        dado_pronto_q;
  logic        erro_q;
  logic        ocupado_q;
  logic        lerMem_q;
  logic        escMem_q;
  logic [31:0] mem_endereco_q;
  logic [31:0] mem_indata_q;
  logic [31:0] inst_dado_q;
  logic [31:0] dado_rdata_q;

`ifdef ARB_ROUND_ROBIN_EN
  logic ptr_q;
  logic ptr_d;
`endif

  arbitro_memoria u_arbitro (
    .inst_req_i (inst_req),
    .dado_req_i (dado_req),
`ifdef ARB_ROUND_ROBIN_EN
    .ptr_i      (ptr_q),
    .ptr_d_o    (ptr_d),
`endif
    .valido_o   (valido_d),
    .porta_o    (porta_d)
  );

  // Route the granted port's request fields; the fetch port never writes.
  always_comb begin
    end_d   = inst_end;
    wdata_d = '0;
    esc_d   = 1'b0;
    if (porta_d == PORTA_DADO) begin
      end_d   = dado_end;
      wdata_d = dado_wdata;
      esc_d   = dado_esc;
    end
    fora_d = fora_de_faixa(end_d, PROFUNDIDADE);
  end

  // Access sequencer: accept, strobe the memory, then pulse completion.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q       <= OCIOSO;
      porta_q        <= PORTA_DADO;
      falha_q        <= 1'b0;
      cont_q         <= '0;
      inst_pronto_q  <= 1'b0;
      dado_pronto_q  <= 1'b0;
      erro_q         <= 1'b0;
      ocupado_q      <= 1'b0;
      lerMem_q       <= 1'b0;
      escMem_q       <= 1'b0;
      mem_endereco_q <= '0;
      mem_indata_q   <= '0;
      inst_dado_q    <= '0;
      dado_rdata_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_q          <= PORTA_DADO;
`endif
    end else begin
      case (estado_q)
        OCIOSO: begin
          inst_pronto_q <= 1'b0;
          dado_pronto_q <= 1'b0;
          erro_q        <= 1'b0;
          if (valido_d) begin
            porta_q        <= porta_d;
            ocupado_q      <= 1'b1;
            mem_endereco_q <= end_d;
            mem_indata_q   <= wdata_d;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_q          <= ptr_d;
`endif
            if (fora_d) begin
              falha_q  <= 1'b1;
              estado_q <= RESPOSTA;
              if (porta_d == PORTA_DADO) begin
                dado_rdata_q <= '0;
              end else begin
                inst_dado_q <= '0;
              end
            end else if (esc_d) begin
              falha_q  <= 1'b0;
              escMem_q <= 1'b1;
              estado_q <= ESCRITA;
            end else begin
              falha_q  <= 1'b0;
              lerMem_q <= 1'b1;
              cont_q   <= CONT_INICIAL;
              estado_q <= LEITURA;
            end
          end
        end
        ESCRITA: begin
          escMem_q <= 1'b0;
          estado_q <= RESPOSTA;
        end
        LEITURA: begin
          if (cont_q == 4'd0) begin
            lerMem_q <= 1'b0;
            estado_q <= RESPOSTA;
            if (porta_q == PORTA_DADO) begin
              dado_rdata_q <= mem_output;
            end else begin
              inst_dado_q <= mem_output;
            end
          end else begin
            cont_q <= cont_q - 4'd1;
          end
        end
        RESPOSTA: begin
          inst_pronto_q <= (porta_q == PORTA_INST);
          dado_pronto_q <= (porta_q == PORTA_DADO);
          erro_q        <= falha_q;
          ocupado_q     <= 1'b0;
          estado_q      <= OCIOSO;
        end
        default: begin
          estado_q <= OCIOSO;
        end
      endcase
    end
  end

  assign inst_pronto  = inst_pronto_q;
  assign inst_dado    = inst_dado_q;
  assign dado_pronto  = dado_pronto_q;
  assign dado_rdata   = dado_rdata_q;
  assign erro         = erro_q;
  assign mem_endereco = mem_endereco_q;
  assign mem_indata   = mem_indata_q;
  assign mem_lerMem   = lerMem_q;
  assign mem_escMem   = escMem_q;
  assign ocupado      = ocupado_q;

endmodule

// File: tb/tb_controlador_memoria.sv
// tb_controlador_memoria: scoreboard bench for controlador_memoria.
// Two instances share one memory model: dut uses LAT_LEITURA=1, dut3 uses
// LAT_LEITURA=3. Expected completions are queued when a request is driven
// and popped when the matching pronto pulse appears.
`timescale 1ns/1ps
module tb_controlador_memoria;
  import memoria_pkg::*;

  localparam int LAT3 = 3;

  typedef struct {
    logic        porta;
    logic [31:0] dado;
    logic        erro;
  } esperado_t;

  esperado_t sb[$];
  int checks = 0;
  int errors = 0;

  logic clock;
  logic reset_n;
  logic carga;

  logic        inst_req, dado_req, dado_esc;
  logic [31:0] inst_end, dado_end, dado_wdata;
  logic        inst_pronto, dado_pronto, erro, ocupado, mem_lerMem, mem_escMem;
  logic [31:0] inst_dado, dado_rdata, mem_endereco, mem_indata, mem_output;

  logic        inst_req3, dado_req3, dado_esc3;
  logic [31:0] inst_end3, dado_end3, dado_wdata3;
  logic        inst_pronto3, dado_pronto3, erro3, ocupado3, mem_lerMem3, mem_escMem3;
  logic [31:0] inst_dado3, dado_rdata3, mem_endereco3, mem_indata3, mem_output3;

  logic [31:0] mem [0:511];
  int rdCount, rdCount3;
  int escCount, lerCount, lerCount3;
  logic [31:0] escAddr, escData;
  logic bothStrobes;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  controlador_memoria #(.LAT_LEITURA(1)) dut (
    .clock(clock), .reset_n(reset_n),
    .inst_req(inst_req), .inst_end(inst_end), .inst_pronto(inst_pronto), .inst_dado(inst_dado),
    .dado_req(dado_req), .dado_esc(dado_esc), .dado_end(dado_end), .dado_wdata(dado_wdata),
    .dado_pronto(dado_pronto), .dado_rdata(dado_rdata), .erro(erro),
    .mem_endereco(mem_endereco), .mem_indata(mem_indata), .mem_lerMem(mem_lerMem),
    .mem_escMem(mem_escMem), .mem_output(mem_output), .ocupado(ocupado)
  );

  controlador_memoria #(.LAT_LEITURA(LAT3)) dut3 (
    .clock(clock), .reset_n(reset_n),
    .inst_req(inst_req3), .inst_end(inst_end3), .inst_pronto(inst_pronto3), .inst_dado(inst_dado3),
    .dado_req(dado_req3), .dado_esc(dado_esc3), .dado_end(dado_end3), .dado_wdata(dado_wdata3),
    .dado_pronto(dado_pronto3), .dado_rdata(dado_rdata3), .erro(erro3),
    .mem_endereco(mem_endereco3), .mem_indata(mem_indata3), .mem_lerMem(mem_lerMem3),
    .mem_escMem(mem_escMem3), .mem_output(mem_output3), .ocupado(ocupado3)
  );

  // Initial memory image.
  function automatic logic [31:0] padrao(input int i);
    if (i == 3) return 32'hCAFEBABE;
    return 32'hA000_0000 | 32'(i);
  endfunction

  // Memory model: synchronous writes, and read data only in the last strobe cycle.
  always @(posedge clock) begin
    if (carga) begin
      for (int i = 0; i < 512; i++) mem[i] <= padrao(i);
    end else begin
      if (mem_escMem && mem_endereco < 32'd512) mem[mem_endereco[8:0]] <= mem_indata;
      if (mem_escMem3 && mem_endereco3 < 32'd512) mem[mem_endereco3[8:0]] <= mem_indata3;
    end
    rdCount  <= mem_lerMem  ? rdCount + 1  : 0;
    rdCount3 <= mem_lerMem3 ? rdCount3 + 1 : 0;
  end

  assign mem_output  = (mem_lerMem  && rdCount  == 0)        ? mem[mem_endereco[8:0]]  : 32'hBAD0BAD0;
  assign mem_output3 = (mem_lerMem3 && rdCount3 == LAT3 - 1) ? mem[mem_endereco3[8:0]] : 32'hBAD0BAD0;

  // Strobe monitor sampled away from the active edge.
  always @(negedge clock) begin
    if (mem_escMem) begin
      escCount = escCount + 1;
      escAddr  = mem_endereco;
      escData  = mem_indata;
    end
    if (mem_lerMem)  lerCount  = lerCount + 1;
    if (mem_lerMem3) lerCount3 = lerCount3 + 1;
    if ((mem_lerMem && mem_escMem) || (mem_lerMem3 && mem_escMem3)) bothStrobes = 1'b1;
  end

  // Waits for a completion pulse on dut; reports which port and after how many cycles.
  task automatic esperar_pronto(input int limite, output bit ok, output int n, output logic p);
    ok = 1'b0;
    n  = 0;
    p  = PORTA_INST;
    while (!ok && n < limite) begin
      @(negedge clock);
      n++;
      if (dado_pronto) begin
        ok = 1'b1;
        p  = PORTA_DADO;
      end else if (inst_pronto) begin
        ok = 1'b1;
        p  = PORTA_INST;
      end
    end
  endtask

  // Drives one request on dut, waits for completion and captures what was returned.
  task automatic transacao(input logic porta, input logic esc, input logic [31:0] ender,
                           input logic [31:0] wd, output bit ok, output int n, output logic p,
                           output logic [31:0] dado, output logic er, output logic depois);
    if (porta == PORTA_DADO) begin
      dado_req = 1'b1; dado_esc = esc; dado_end = ender; dado_wdata = wd;
    end else begin
      inst_req = 1'b1; inst_end = ender;
    end
    esperar_pronto(20, ok, n, p);
    dado = (p == PORTA_DADO) ? dado_rdata : inst_dado;
    er   = erro;
    inst_req = 1'b0;
    dado_req = 1'b0;
    @(negedge clock);
    depois = inst_pronto | dado_pronto | erro;
  endtask

  task automatic test_reset();
    bit ok; int n; logic p; esperado_t e; logic [31:0] d; logic er, dep; int vistos;
    checks++;
    if ({inst_pronto, dado_pronto, erro, ocupado, mem_lerMem, mem_escMem} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b, expected 000000",
               {inst_pronto, dado_pronto, erro, ocupado, mem_lerMem, mem_escMem});
    end
    checks++;
    if ({mem_endereco, mem_indata, dado_rdata, inst_dado} !== 128'h0) begin
      errors++;
      $display("[TB] FAIL reset_data: got %h %h %h %h, expected all 0",
               mem_endereco, mem_indata, dado_rdata, inst_dado);
    end
    reset_n = 1'b1;
    @(negedge clock);
    dado_req = 1'b1; dado_esc = 1'b0; dado_end = 32'd3;
    @(negedge clock);
    checks++;
    if (mem_lerMem !== 1'b1) begin
      errors++;
      $display("[TB] FAIL read_started: got %b, expected 1", mem_lerMem);
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if ({mem_lerMem, ocupado, dado_pronto} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_abort: got %b, expected 000", {mem_lerMem, ocupado, dado_pronto});
    end
    dado_req = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    vistos = 0;
    repeat (3) begin
      @(negedge clock);
      if (dado_pronto || inst_pronto || ocupado) vistos++;
    end
    checks++;
    if (vistos !== 0) begin
      errors++;
      $display("[TB] FAIL no_pronto_after_abort: got %0d, expected 0", vistos);
    end
    sb.push_back('{PORTA_DADO, 32'hCAFEBABE, 1'b0});
    transacao(PORTA_DADO, 1'b0, 32'd3, 32'h0, ok, n, p, d, er, dep);
    e = sb.pop_front();
    checks++;
    if (!ok || p !== e.porta || n !== 3) begin
      errors++;
      $display("[TB] FAIL read3_timing: got ok=%0d port=%0d n=%0d, expected ok=1 port=%0d n=3", ok, p, n, e.porta);
    end
    checks++;
    if (d !== e.dado || er !== e.erro) begin
      errors++;
      $display("[TB] FAIL read3_data: got %h erro=%b, expected %h erro=%b", d, er, e.dado, e.erro);
    end
  endtask

  task automatic test_write_read();
    bit ok; int n; logic p; esperado_t e; logic [31:0] d; logic er, dep;
    escCount = 0; lerCount = 0;
    sb.push_back('{PORTA_DADO, 32'hCAFEBABE, 1'b0});
    transacao(PORTA_DADO, 1'b1, 32'd10, 32'hDEADBEEF, ok, n, p, d, er, dep);
    e = sb.pop_front();
    checks++;
    if (!ok || p !== e.porta || n !== 3) begin
      errors++;
      $display("[TB] FAIL write_timing: got ok=%0d port=%0d n=%0d, expected ok=1 port=%0d n=3", ok, p, n, e.porta);
    end
    checks++;
    if (escCount !== 1 || lerCount !== 0) begin
      errors++;
      $display("[TB] FAIL write_strobe: got esc=%0d ler=%0d, expected esc=1 ler=0", escCount, lerCount);
    end
    checks++;
    if (escAddr !== 32'd10 || escData !== 32'hDEADBEEF) begin
      errors++;
      $display("[TB] FAIL write_bus: got %h %h, expected 0000000a deadbeef", escAddr, escData);
    end
    checks++;
    if (d !== e.dado || dep !== 1'b0) begin
      errors++;
      $display("[TB] FAIL write_hold: got %h pulse_after=%b, expected %h pulse_after=0", d, dep, e.dado);
    end
    sb.push_back('{PORTA_DADO, 32'hDEADBEEF, 1'b0});
    transacao(PORTA_DADO, 1'b0, 32'd10, 32'h0, ok, n, p, d, er, dep);
    e = sb.pop_front();
    checks++;
    if (!ok || p !== e.porta || n !== 3 || d !== e.dado || er !== e.erro) begin
      errors++;
      $display("[TB] FAIL readback10: got ok=%0d n=%0d %h erro=%b, expected ok=1 n=3 %h erro=%b", ok, n, d, er, e.dado, e.erro);
    end
  endtask

  task automatic test_simultaneous();
    bit ok; int n; logic p; esperado_t e; logic [31:0] d, obs; logic er, dep; int rodadas; logic primeira;
`ifdef ARB_ROUND_ROBIN_EN
    rodadas = 3;
`else
    rodadas = 2;
`endif
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    for (int r = 0; r < rodadas; r++) begin
      primeira = PORTA_DADO;
      if (r == 2) begin
        transacao(PORTA_DADO, 1'b0, 32'd8, 32'h0, ok, n, p, d, er, dep);
        primeira = PORTA_INST;
      end
      if (primeira == PORTA_DADO) begin
        sb.push_back('{PORTA_DADO, padrao(8), 1'b0});
        sb.push_back('{PORTA_INST, padrao(4), 1'b0});
      end else begin
        sb.push_back('{PORTA_INST, padrao(4), 1'b0});
        sb.push_back('{PORTA_DADO, padrao(8), 1'b0});
      end
      inst_req = 1'b1; inst_end = 32'd4;
      dado_req = 1'b1; dado_esc = 1'b0; dado_end = 32'd8;
      for (int k = 0; k < 2; k++) begin
        esperar_pronto(20, ok, n, p);
        e = sb.pop_front();
        obs = (p == PORTA_DADO) ? dado_rdata : inst_dado;
        checks++;
        if (!ok || p !== e.porta || n !== 3 || (inst_pronto && dado_pronto)) begin
          errors++;
          $display("[TB] FAIL collision_order r%0d k%0d: got ok=%0d port=%0d n=%0d, expected port=%0d n=3", r, k, ok, p, n, e.porta);
        end
        checks++;
        if (obs !== e.dado) begin
          errors++;
          $display("[TB] FAIL collision_data r%0d k%0d: got %h, expected %h", r, k, obs, e.dado);
        end
        if (!ok) begin
          inst_req = 1'b0; dado_req = 1'b0;
        end else if (p == PORTA_DADO) begin
          dado_req = 1'b0;
        end else begin
          inst_req = 1'b0;
        end
      end
      @(negedge clock);
    end
  endtask

  task automatic test_out_of_range();
    bit ok; int n; logic p; esperado_t e; logic [31:0] d; logic er, dep;
    escCount = 0; lerCount = 0;
    sb.push_back('{PORTA_INST, 32'h0, 1'b1});
    transacao(PORTA_INST, 1'b0, 32'd512, 32'h0, ok, n, p, d, er, dep);
    e = sb.pop_front();
    checks++;
    if (!ok || p !== e.porta || n !== 2) begin
      errors++;
      $display("[TB] FAIL range_timing: got ok=%0d port=%0d n=%0d, expected ok=1 port=0 n=2", ok, p, n);
    end
    checks++;
    if (d !== e.dado || er !== e.erro || dep !== 1'b0) begin
      errors++;
      $display("[TB] FAIL range_result: got %h erro=%b after=%b, expected %h erro=1 after=0", d, er, dep, e.dado);
    end
    checks++;
    if (escCount + lerCount !== 0) begin
      errors++;
      $display("[TB] FAIL range_no_strobe: got %0d strobe cycles, expected 0", escCount + lerCount);
    end
    sb.push_back('{PORTA_INST, padrao(511), 1'b0});
    transacao(PORTA_INST, 1'b0, 32'd511, 32'h0, ok, n, p, d, er, dep);
    e = sb.pop_front();
    checks++;
    if (!ok || n !== 3 || d !== e.dado || er !== e.erro) begin
      errors++;
      $display("[TB] FAIL last_word: got ok=%0d n=%0d %h erro=%b, expected ok=1 n=3 %h erro=0", ok, n, d, er, e.dado);
    end
  endtask

  task automatic test_extended_read();
    bit ok; int n; esperado_t e; logic [31:0] obs;
    lerCount3 = 0;
    sb.push_back('{PORTA_DADO, padrao(20), 1'b0});
    dado_req3 = 1'b1; dado_esc3 = 1'b0; dado_end3 = 32'd20;
    ok = 1'b0; n = 0;
    while (!ok && n < 20) begin
      @(negedge clock);
      n++;
      if (dado_pronto3) ok = 1'b1;
    end
    obs = dado_rdata3;
    dado_req3 = 1'b0;
    e = sb.pop_front();
    checks++;
    if (!ok || n !== LAT3 + 2) begin
      errors++;
      $display("[TB] FAIL lat3_timing: got ok=%0d n=%0d, expected ok=1 n=%0d", ok, n, LAT3 + 2);
    end
    checks++;
    if (lerCount3 !== LAT3) begin
      errors++;
      $display("[TB] FAIL lat3_strobe: got %0d cycles, expected %0d", lerCount3, LAT3);
    end
    checks++;
    if (obs !== e.dado) begin
      errors++;
      $display("[TB] FAIL lat3_data: got %h, expected %h", obs, e.dado);
    end
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    bit ok; int n; logic p; esperado_t e; int extra;
    for (int i = 0; i < 4; i++) sb.push_back('{PORTA_DADO, padrao(i), 1'b0});
    dado_req = 1'b1; dado_esc = 1'b0; dado_end = 32'd0;
    for (int i = 0; i < 4; i++) begin
      esperar_pronto(20, ok, n, p);
      e = sb.pop_front();
      checks++;
      if (!ok || p !== e.porta || n !== 3 || ocupado !== 1'b0) begin
        errors++;
        $display("[TB] FAIL b2b_timing %0d: got ok=%0d port=%0d n=%0d ocupado=%b, expected ok=1 port=1 n=3 ocupado=0", i, ok, p, n, ocupado);
      end
      checks++;
      if (dado_rdata !== e.dado) begin
        errors++;
        $display("[TB] FAIL b2b_data %0d: got %h, expected %h", i, dado_rdata, e.dado);
      end
      if (i < 3 && ok) dado_end = 32'(i + 1);
      else begin
        dado_req = 1'b0;
        if (!ok) break;
      end
    end
    dado_req = 1'b0;
    extra = 0;
    repeat (4) begin
      @(negedge clock);
      if (dado_pronto || ocupado) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("[TB] FAIL b2b_quiet: got %0d busy cycles, expected 0", extra);
    end
  endtask

  initial begin
    reset_n = 1'b0; carga = 1'b1;
    inst_req = 1'b0; inst_end = '0; dado_req = 1'b0; dado_esc = 1'b0; dado_end = '0; dado_wdata = '0;
    inst_req3 = 1'b0; inst_end3 = '0; dado_req3 = 1'b0; dado_esc3 = 1'b0; dado_end3 = '0; dado_wdata3 = '0;
    escCount = 0; lerCount = 0; lerCount3 = 0; escAddr = '0; escData = '0; bothStrobes = 1'b0;
    @(negedge clock);
    carga = 1'b0;
    @(negedge clock);
    test_reset();
    test_write_read();
    test_simultaneous();
    test_out_of_range();
    test_extended_read();
    test_back_to_back();
    checks++;
    if (bothStrobes !== 1'b0) begin
      errors++;
      $display("[TB] FAIL exclusive_strobes: got %b, expected 0", bothStrobes);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/controlador_memoria.md
Name: controlador_memoria

Overview:
- Initiator side of the shared data/instruction memory: the master that drives the memory's address, write-data, read strobe and write strobe, and samples its read-data output.
- Arbitrates two CPU request ports onto the single memory interface:
  - instruction fetch port, read-only;
  - data port, read/write.
- Each access is sequenced by an FSM with a one-cycle completion pulse back to the requester.

Parameters:
- PROFUNDIDADE, 512, number of memory words; a valid word address is any value below PROFUNDIDADE.
- LAT_LEITURA, 1, cycles the read strobe is held before the read data is captured (1..15).

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- inst_req  input  1  instruction read request; held high until inst_pronto.
- inst_end  input  32  instruction word address.
- inst_pronto  output  1  one-cycle completion pulse, instruction port.
- inst_dado  output  32  instruction read data; valid while inst_pronto=1.
- dado_req  input  1  data request; held high until dado_pronto.
- dado_esc  input  1  1=write, 0=read; sampled with dado_req.
- dado_end  input  32  data word address.
- dado_wdata  input  32  write data.
- dado_pronto  output  1  one-cycle completion pulse, data port.
- dado_rdata  output  32  data read result; valid while dado_pronto=1.
- erro  output  1  pulses with pronto when the address was out of range.
- mem_endereco  output  32  address to memory.
- mem_indata  output  32  write data to memory.
- mem_lerMem  output  1  memory read strobe.
- mem_escMem  output  1  memory write strobe.
- mem_output  input  32  memory read data.
- ocupado  output  1  high in every state except OCIOSO.

Behaviour:
- Reset, asynchronous, while reset_n=0:
  - every output is 0; FSM goes to OCIOSO; grant pointer points to the data port.
  - Reset mid-access aborts it: strobes drop immediately and no pronto is issued.
- All outputs are registered.
- OCIOSO state:
  - If either req is high at a rising edge, latch port id, address, wdata and esc; inst port latches esc=0.
  - If both requests are high, the data port wins.
  - Address >= PROFUNDIDADE: go to RESPOSTA with erro set; no strobe is issued.
  - Otherwise esc=1 goes to ESCRITA and esc=0 goes to LEITURA.
  - mem_endereco and mem_indata take the latched values on the same edge.
- ESCRITA state:
  - mem_escMem=1 for exactly one cycle, then RESPOSTA.
- LEITURA state:
  - mem_lerMem=1 for LAT_LEITURA cycles, counted by an internal counter.
  - On the edge that ends the last cycle, mem_output is captured into the granted port's data register, then RESPOSTA.
- RESPOSTA state:
  - The granted port's pronto=1 for one cycle; erro=1 if flagged; strobes are 0.
  - Then OCIOSO.
- Latency, with request sampled at edge k:
  - write: pronto is high in the cycle after edge k+2;
  - read: pronto is high in the cycle after edge k+1+LAT_LEITURA;
  - error: pronto is high in the cycle after edge k+1.
- Throughput: a new request is accepted no earlier than the edge ending RESPOSTA. A req still high in the OCIOSO cycle after pronto is treated as a new request.
- Data outputs:
  - inst_dado and dado_rdata hold their last value between accesses.
  - On error the granted port's data register is cleared to 0.
- mem_lerMem and mem_escMem are never high in the same cycle.
- Address and data inputs may change while not granted; they are not sampled outside OCIOSO.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined:
  - When both req are high in OCIOSO, grant goes to the port not served last.
  - The grant pointer updates on every acceptance.
- Undefined: fixed priority, data port always wins.

Decomposition:
- Shared package memoria_pkg holds:
  - the FSM state encoding: OCIOSO=2'd0, ESCRITA=2'd1, LEITURA=2'd2, RESPOSTA=2'd3;
  - port id constants PORTA_INST=1'b0 and PORTA_DADO=1'b1;
  - the default PROFUNDIDADE.
- One sub-module: arbitro_memoria, the combinational grant selection including the optional round-robin pointer logic.
- FSM, counter and registers stay in the top module.

Test Plan:
- Reset with memory model preloaded:
  - Stimulus: reset_n=0 mid-read, then release.
  - Required: strobes drop immediately; no pronto; ocupado=0.
  - Stimulus: next dado read of address 3 (=32'hCAFEBABE).
  - Required: dado_rdata=32'hCAFEBABE with dado_pronto.
- Data write then read, LAT_LEITURA=1:
  - Stimulus: dado_req, esc=1, end=10, wdata=32'hDEADBEEF.
  - Required: mem_escMem high exactly one cycle with mem_endereco=10; dado_pronto 3 cycles after acceptance.
  - Stimulus: read back address 10.
  - Required: dado_rdata=32'hDEADBEEF.
- Simultaneous requests: inst_req (end=4) and dado_req (read end=8) high in the same cycle.
  - Without the macro: data served first, inst next; inst_req held throughout.
  - With ARB_ROUND_ROBIN_EN, two back-to-back collisions: served order is data, inst, data, inst.
- Out-of-range access:
  - Stimulus: inst_req with end=512.
  - Required: no strobe; inst_pronto=1, erro=1, inst_dado=0, two cycles after acceptance.
- Extended read, LAT_LEITURA=3:
  - Stimulus: read request.
  - Required: mem_lerMem high exactly 3 cycles; mem_output sampled at the end of the third; pronto follows.
- Back-to-back requests:
  - Stimulus: dado_req held high across 4 reads of addresses 0..3.
  - Required: 4 pronto pulses, each separated by at least one OCIOSO cycle; correct data on each.
